// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encoding and default sizing for the FIFO serializer
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int DEFAULT_DATA_WIDTH   = 5;
  localparam int DEFAULT_CLKS_PER_BIT = 4;

endpackage

// File: rtl/bit_timer.sv
// rtl/bit_timer.sv - bit-period counter, wraps every CLKS_PER_BIT cycles and flags the last one
module bit_timer #(
  parameter int CLKS_PER_BIT = serial_pkg::DEFAULT_CLKS_PER_BIT
) (
  input  logic CLK,
  input  logic RESET,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
    end else if (restart || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/fifo_serializer.sv
// rtl/fifo_serializer.sv - pops words from a FIFO and sends them as start/data/stop serial frames
module fifo_serializer
  import serial_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  empty,
  output logic                  ren,
  input  logic                  enable,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0] BIT_LAST = IW'(DATA_WIDTH - 1);

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_next;
  logic [IW-1:0]         bit_idx;
  logic                  tick;

  // Counter is held at zero while idle so every frame starts on a full bit period.
  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .CLK    (CLK),
    .RESET  (RESET),
    .restart(state == IDLE),
    .tick   (tick)
  );

  assign shreg_next = shreg >> 1;
  assign ren = ~RESET & enable & ~empty &
               ((state == IDLE) | ((state == STOP) & tick));
  assign frame_done = (state == STOP) & tick;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      shreg   <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ren) begin
            shreg   <= rdata;
            bit_idx <= '0;
            tx      <= 1'b0;
            busy    <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (tick) begin
            tx    <= shreg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == BIT_LAST) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + IW'(1);
              shreg   <= shreg_next;
              tx      <= shreg_next[0];
            end
          end
        end
        STOP: begin
          // Back-to-back frames reload here so no idle cycle appears on the line.
          if (tick) begin
            if (ren) begin
              shreg   <= rdata;
              bit_idx <= '0;
              tx      <= 1'b0;
              state   <= START;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_serializer.sv
// tb/tb_fifo_serializer.sv - directed self-checking bench for fifo_serializer
module tb_fifo_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [4:0] rdata, rdata1;
  logic       empty, empty1;
  logic       ren, ren1;
  logic       tx, tx1;
  logic       busy, busy1;
  logic       fd, fd1;

  logic [4:0] mem [16];
  logic [4:0] mem1 [16];
  int rd = 0, wr = 0, rd1 = 0, wr1 = 0;

  int n_tests = 0;
  int n_fail  = 0;

  logic tr_ren [0:63];
  logic tr_tx  [0:63];
  logic tr_busy[0:63];
  logic tr_fd  [0:63];

  typedef struct {
    int   k;
    logic ren;
    logic tx;
    logic busy;
    logic fd;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  fifo_serializer dut (
    .CLK(clk), .RESET(rst), .rdata(rdata), .empty(empty), .ren(ren),
    .enable(enable), .tx(tx), .busy(busy), .frame_done(fd)
  );

  fifo_serializer #(.DATA_WIDTH(5), .CLKS_PER_BIT(1)) dut1 (
    .CLK(clk), .RESET(rst), .rdata(rdata1), .empty(empty1), .ren(ren1),
    .enable(enable), .tx(tx1), .busy(busy1), .frame_done(fd1)
  );

  assign empty  = (rd == wr);
  assign rdata  = mem[rd % 16];
  assign empty1 = (rd1 == wr1);
  assign rdata1 = mem1[rd1 % 16];

  always @(posedge clk) begin
    if (ren)  rd  <= rd + 1;
    if (ren1) rd1 <= rd1 + 1;
  end

  task automatic push(input logic [4:0] w);
    mem[wr % 16] = w;
    wr = wr + 1;
  endtask

  task automatic push1(input logic [4:0] w);
    mem1[wr1 % 16] = w;
    wr1 = wr1 + 1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int k, input logic r, input logic t, input logic b, input logic f);
    vec_t v;
    v.k = k; v.ren = r; v.tx = t; v.busy = b; v.fd = f;
    vecs.push_back(v);
  endtask

  task automatic capture(input int n, input int en_off);
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      tr_ren[k] = ren; tr_tx[k] = tx; tr_busy[k] = busy; tr_fd[k] = fd;
      if (k == en_off) enable = 1'b0;
    end
  endtask

  task automatic apply_table(input string tag);
    foreach (vecs[i]) begin
      check($sformatf("%s k=%0d ren", tag, vecs[i].k), 8'(tr_ren[vecs[i].k]), 8'(vecs[i].ren));
      check($sformatf("%s k=%0d tx", tag, vecs[i].k), 8'(tr_tx[vecs[i].k]), 8'(vecs[i].tx));
      check($sformatf("%s k=%0d busy", tag, vecs[i].k), 8'(tr_busy[vecs[i].k]), 8'(vecs[i].busy));
      check($sformatf("%s k=%0d frame_done", tag, vecs[i].k), 8'(tr_fd[vecs[i].k]), 8'(vecs[i].fd));
    end
    vecs.delete();
  endtask

  function automatic int count_ren(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) if (tr_ren[k] === 1'b1) c++;
    return c;
  endfunction

  initial begin
    logic [4:0] w6 [3];
    int bad;

    rst = 1'b1;
    enable = 1'b1;
    push(5'b10110);
    #12;
    check("reset ren", 8'(ren), 8'd0);
    check("reset tx", 8'(tx), 8'd1);
    check("reset busy", 8'(busy), 8'd0);
    check("reset frame_done", 8'(fd), 8'd0);
    check("reset tx cpb1", 8'(tx1), 8'd1);

    @(negedge clk);
    enable = 1'b0;
    rst = 1'b0;
    #1;
    check("disabled after reset ren", 8'(ren), 8'd0);

    // single frame of 10110
    @(negedge clk);
    enable = 1'b1;
    capture(30, -1);
    add(0, 1, 1, 0, 0);  add(1, 0, 0, 1, 0);  add(4, 0, 0, 1, 0);
    add(5, 0, 0, 1, 0);  add(8, 0, 0, 1, 0);  add(9, 0, 1, 1, 0);
    add(13, 0, 1, 1, 0); add(16, 0, 1, 1, 0); add(17, 0, 0, 1, 0);
    add(20, 0, 0, 1, 0); add(21, 0, 1, 1, 0); add(24, 0, 1, 1, 0);
    add(25, 0, 1, 1, 0); add(27, 0, 1, 1, 0); add(28, 0, 1, 1, 1);
    add(29, 0, 1, 0, 0);
    apply_table("single");
    check("single ren count", 8'(count_ren(30)), 8'd1);

    // back-to-back 1F then 00
    @(negedge clk);
    push(5'h1F);
    push(5'h00);
    capture(58, -1);
    add(0, 1, 1, 0, 0);  add(1, 0, 0, 1, 0);  add(5, 0, 1, 1, 0);
    add(24, 0, 1, 1, 0); add(28, 1, 1, 1, 1); add(29, 0, 0, 1, 0);
    add(32, 0, 0, 1, 0); add(33, 0, 0, 1, 0); add(52, 0, 0, 1, 0);
    add(53, 0, 1, 1, 0); add(56, 0, 1, 1, 1); add(57, 0, 1, 0, 0);
    apply_table("b2b");
    check("b2b ren count", 8'(count_ren(58)), 8'd2);

    // enable low with data waiting, then enable dropped mid-frame
    @(negedge clk);
    enable = 1'b0;
    push(5'b01010);
    push(5'b11111);
    capture(10, -1);
    bad = 0;
    for (int k = 0; k < 10; k++) if (tr_ren[k] !== 1'b0 || tr_busy[k] !== 1'b0) bad++;
    check("disabled no pop cycles", 8'(bad), 8'd0);
    @(negedge clk);
    enable = 1'b1;
    capture(36, 10);
    add(0, 1, 1, 0, 0);  add(5, 0, 0, 1, 0);  add(9, 0, 1, 1, 0);
    add(12, 0, 1, 1, 0); add(28, 0, 1, 1, 1); add(29, 0, 1, 0, 0);
    add(35, 0, 1, 0, 0);
    apply_table("en_drop");
    check("en_drop ren count", 8'(count_ren(36)), 8'd1);

    // reset at cycle 12 of a frame of 11111, then frame 00001 after release
    @(negedge clk);
    push(5'b00001);
    enable = 1'b1;
    #1;
    check("rst seq pop", 8'(ren), 8'd1);
    for (int k = 1; k <= 12; k++) @(negedge clk);
    #1;
    check("rst seq k12 busy", 8'(busy), 8'd1);
    rst = 1'b1;
    #1;
    check("rst mid tx", 8'(tx), 8'd1);
    check("rst mid busy", 8'(busy), 8'd0);
    check("rst mid ren", 8'(ren), 8'd0);
    check("rst mid frame_done", 8'(fd), 8'd0);
    @(negedge clk);
    #1;
    check("rst held ren", 8'(ren), 8'd0);
    check("rst held tx", 8'(tx), 8'd1);
    rst = 1'b0;
    #1;
    check("post rst pop", 8'(ren), 8'd1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("post rst k=%0d tx", k), 8'(tx), (k == 5) ? 8'd1 : 8'd0);
      check($sformatf("post rst k=%0d busy", k), 8'(busy), 8'd1);
      check($sformatf("post rst k=%0d ren", k), 8'(ren), 8'd0);
    end
    repeat (30) @(negedge clk);

    // FIFO empty, enable toggling
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      enable = ~enable;
      #1;
      if (ren !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("empty idle cycles bad", 8'(bad), 8'd0);

    // CLKS_PER_BIT=1, three words queued
    w6[0] = 5'b10110;
    w6[1] = 5'b00011;
    w6[2] = 5'b11000;
    @(negedge clk);
    push1(w6[0]);
    push1(w6[1]);
    push1(w6[2]);
    enable = 1'b1;
    for (int k = 0; k <= 22; k++) begin
      logic er, et, eb, ef;
      int pos, fr;
      if (k > 0) @(negedge clk);
      #1;
      er = (k == 0 || k == 7 || k == 14);
      ef = (k == 7 || k == 14 || k == 21);
      eb = (k >= 1 && k <= 21);
      et = 1'b1;
      if (eb) begin
        pos = (k - 1) % 7;
        fr  = (k - 1) / 7;
        if (pos == 0) et = 1'b0;
        else if (pos <= 5) et = w6[fr][pos-1];
      end
      check($sformatf("cpb1 k=%0d ren", k), 8'(ren1), 8'(er));
      check($sformatf("cpb1 k=%0d tx", k), 8'(tx1), 8'(et));
      check($sformatf("cpb1 k=%0d busy", k), 8'(busy1), 8'(eb));
      check($sformatf("cpb1 k=%0d frame_done", k), 8'(fd1), 8'(ef));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
